// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Groups the requester handshakes (IF fetch, ME load/store) and the byte-wide
// RAM port of mem_port_arbiter into one bundle.
//   slave  : arbiter view (takes requests and RAM read data, drives results and RAM strobes)
//   master : environment view (requesters plus RAM model)
// Signals:
//   if_req_i/if_addr_i, if_data_o/if_done_o      instruction fetch side
//   me_req_i/me_we_i/me_size_i/me_addr_i/me_wdata_i,
//   me_rdata_o/me_done_o                         memory stage side
//   mem_addr_o/mem_we_o/mem_wdata_o/mem_rdata_i  byte RAM port
//   busy_o                                       arbiter not idle
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic [31:0]       if_data_o;
  logic              if_done_o;

  logic              me_req_i;
  logic              me_we_i;
  logic [1:0]        me_size_i;
  logic [ADDR_W-1:0] me_addr_i;
  logic [31:0]       me_wdata_i;
  logic [31:0]       me_rdata_o;
  logic              me_done_o;

  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_we_o;
  logic [7:0]        mem_wdata_o;
  logic [7:0]        mem_rdata_i;

  logic              busy_o;

  modport slave (
    input  if_req_i, if_addr_i,
    input  me_req_i, me_we_i, me_size_i, me_addr_i, me_wdata_i,
    input  mem_rdata_i,
    output if_data_o, if_done_o,
    output me_rdata_o, me_done_o,
    output mem_addr_o, mem_we_o, mem_wdata_o,
    output busy_o
  );

  modport master (
    output if_req_i, if_addr_i,
    output me_req_i, me_we_i, me_size_i, me_addr_i, me_wdata_i,
    output mem_rdata_i,
    input  if_data_o, if_done_o,
    input  me_rdata_o, me_done_o,
    input  mem_addr_o, mem_we_o, mem_wdata_o,
    input  busy_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the CPU's single byte-wide memory port between instruction fetch (IF)
// and the memory stage (ME). Each word/halfword/byte access is split into
// sequential single-byte RAM cycles; loads are reassembled little-endian and
// returned with a one-cycle done pulse. ME has strict priority at grant time;
// there is no preemption once an access has started.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - mem_port_arbiter_if.slave (requests, results, RAM port, busy_o)
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no access; grant ME first, else IF
// ISSUE  | drive RAM byte address base+cnt (write strobe for stores)
// LAST   | loads only: no RAM access, capture the final read byte
// DONE   | pulse owner's done for one cycle, then back to IDLE
module mem_port_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_LAST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        cnt_q;
  logic [1:0]        last_q;       // index of the final byte (nbytes-1)
  logic              owner_me_q;
  logic [ADDR_W-1:0] base_q;
  logic              we_q;
  logic [31:0]       wdata_q;
  logic [31:0]       if_data_q;
  logic [31:0]       me_rdata_q;

  logic              grant;
  logic              grant_me;
  logic              grant_if;
  logic [1:0]        me_last;
  logic              capture;
  logic [1:0]        lane;

  assign grant_me = (state_q == S_IDLE) && bus.me_req_i;
  assign grant_if = (state_q == S_IDLE) && !bus.me_req_i && bus.if_req_i;
  assign grant    = grant_me || grant_if;

  // Size 11 is treated as a word access.
  always_comb begin
    me_last = 2'd3;
    case (bus.me_size_i)
      2'b00:   me_last = 2'd0;
      2'b01:   me_last = 2'd1;
      default: me_last = 2'd3;
    endcase
  end

  // RAM read data lags its address by one cycle, so the byte arriving during
  // ISSUE(cnt=k) belongs to lane k-1, and LAST picks up the final lane.
  assign capture = !we_q &&
                   (((state_q == S_ISSUE) && (cnt_q != 2'd0)) || (state_q == S_LAST));
  assign lane    = (state_q == S_LAST) ? last_q : (cnt_q - 2'd1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (grant) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (cnt_q == last_q) state_d = we_q ? S_DONE : S_LAST;
      end
      S_LAST:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Latched request, byte counter and read-data assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= 2'd0;
      last_q     <= 2'd0;
      owner_me_q <= 1'b0;
      base_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= 32'd0;
      if_data_q  <= 32'd0;
      me_rdata_q <= 32'd0;
    end else begin
      if (grant) begin
        cnt_q      <= 2'd0;
        owner_me_q <= grant_me;
        base_q     <= grant_me ? bus.me_addr_i : bus.if_addr_i;
        last_q     <= grant_me ? me_last : 2'd3;
        we_q       <= grant_me && bus.me_we_i;
        wdata_q    <= grant_me ? bus.me_wdata_i : 32'd0;
        // Clearing on grant makes unused upper bytes of short loads read 0.
        if (grant_if) begin
          if_data_q <= 32'd0;
        end else if (!bus.me_we_i) begin
          me_rdata_q <= 32'd0;
        end
      end else if ((state_q == S_ISSUE) && (cnt_q != last_q)) begin
        cnt_q <= cnt_q + 2'd1;
      end

      if (capture) begin
        if (owner_me_q) begin
          me_rdata_q[{lane, 3'b000} +: 8] <= bus.mem_rdata_i;
        end else begin
          if_data_q[{lane, 3'b000} +: 8] <= bus.mem_rdata_i;
        end
      end
    end
  end

  // Outputs
  always_comb begin
    bus.mem_addr_o  = '0;
    bus.mem_we_o    = 1'b0;
    bus.mem_wdata_o = 8'd0;
    bus.if_done_o   = 1'b0;
    bus.me_done_o   = 1'b0;
    bus.busy_o      = (state_q != S_IDLE);
    case (state_q)
      S_ISSUE: begin
        bus.mem_addr_o = base_q + ADDR_W'(cnt_q);
        if (we_q) begin
          bus.mem_we_o    = 1'b1;
          bus.mem_wdata_o = wdata_q[{cnt_q, 3'b000} +: 8];
        end
      end
      S_DONE: begin
        bus.if_done_o = !owner_me_q;
        bus.me_done_o = owner_me_q;
      end
      default: ;
    endcase
  end

  assign bus.if_data_o  = if_data_q;
  assign bus.me_rdata_o = me_rdata_q;

endmodule
